// File: rtl/fetch_seq_pkg.sv
// Shared constants and types for the 3-wide fetch sequencer.
package fetch_seq_pkg;
    localparam int          ISSUE_W      = 3;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] BUNDLE_STEP  = 32'd12;
    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    // Decode may ask for more than is buffered; never take more than exists.
    function automatic logic [1:0] clamp_take(input logic [1:0] take, input logic [1:0] cnt);
        return (take > cnt) ? cnt : take;
    endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// Fetch-side bus: SRAM address/data, redirect, and decode hand-off.
interface fetch_seq_if;
    logic [31:0] fetch_pc0, fetch_pc1, fetch_pc2;
    logic        fetch_en;
    logic [31:0] instr0, instr1, instr2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [2:0]  dec_mask;
    logic [31:0] dec_pc0, dec_pc1, dec_pc2;
    logic [31:0] dec_instr0, dec_instr1, dec_instr2;
    logic [1:0]  dec_take;

    modport master (
        output fetch_pc0, fetch_pc1, fetch_pc2, fetch_en,
        input  instr0, instr1, instr2, redirect_valid, redirect_pc,
        output dec_valid, dec_mask, dec_pc0, dec_pc1, dec_pc2,
        output dec_instr0, dec_instr1, dec_instr2,
        input  dec_take
    );
    modport slave (
        input  fetch_pc0, fetch_pc1, fetch_pc2, fetch_en,
        output instr0, instr1, instr2, redirect_valid, redirect_pc,
        input  dec_valid, dec_mask, dec_pc0, dec_pc1, dec_pc2,
        input  dec_instr0, dec_instr1, dec_instr2,
        output dec_take
    );
endinterface

// File: rtl/adder_32.sv
// Plain 32-bit modulo adder used for all PC increments.
module adder_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// File: rtl/fetch_seq_buf3.sv
// 3-slot holding buffer: captures a whole bundle or shifts out consumed slots.
module fetch_buf3
    import fetch_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_capture,
    input  slot_t [ISSUE_W-1:0]  i_cap,
    input  logic [1:0]           i_take,
    output logic [1:0]           o_cnt,
    output logic [1:0]           o_rem,
    output slot_t [ISSUE_W-1:0]  o_slot
);
    logic [1:0]          r_cnt;
    slot_t [ISSUE_W-1:0] r_slot;
    slot_t [ISSUE_W-1:0] w_shift;
    logic [1:0]          w_take;
    logic [1:0]          w_rem;

    assign w_take = clamp_take(i_take, r_cnt);
    assign w_rem  = r_cnt - w_take;

    // Slots past the remaining count are zeroed so outputs never need masking.
    always_comb begin
        for (int j = 0; j < ISSUE_W; j++) begin
            logic [1:0] w_src;
            w_shift[j] = '{pc: 32'd0, instr: NOP_INSTR};
            w_src      = 2'(j) + w_take;
            if (2'(j) < w_rem && w_src < 2'(ISSUE_W))
                w_shift[j] = r_slot[w_src];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_slot <= '0;
        end else if (i_flush) begin
            r_cnt  <= 2'd0;
            r_slot <= '0;
        end else if (i_capture) begin
            r_cnt  <= 2'(ISSUE_W);
            r_slot <= i_cap;
        end else begin
            r_cnt  <= w_rem;
            r_slot <= w_shift;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_rem  = w_rem;
    assign o_slot = r_slot;
endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns pc_q, redirect priority and fetch_en; buffering in fetch_buf3.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_seq_if.master  bus
);
    logic [31:0]         r_pc;
    logic [31:0]         w_pc4, w_pc8, w_pc12;
    logic [1:0]          w_cnt, w_rem;
    logic                w_fetch_en;
    slot_t [ISSUE_W-1:0] w_cap, w_slot;

    adder_32 u_add4  (.i_a(r_pc), .i_b(PC_STEP),       .o_sum(w_pc4));
    adder_32 u_add8  (.i_a(r_pc), .i_b(PC_STEP << 1),  .o_sum(w_pc8));
    adder_32 u_add12 (.i_a(r_pc), .i_b(BUNDLE_STEP),   .o_sum(w_pc12));

    // A redirect wins over capture even when the buffer would have drained.
    assign w_fetch_en = (w_rem == 2'd0) & ~bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_pc <= RESET_PC;
        else if (bus.redirect_valid) r_pc <= {bus.redirect_pc[31:2], 2'b00};
        else if (w_fetch_en)         r_pc <= w_pc12;
    end

    assign w_cap[0] = '{pc: r_pc,  instr: bus.instr0};
    assign w_cap[1] = '{pc: w_pc4, instr: bus.instr1};
    assign w_cap[2] = '{pc: w_pc8, instr: bus.instr2};

    fetch_buf3 u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (bus.redirect_valid),
        .i_capture (w_fetch_en),
        .i_cap     (w_cap),
        .i_take    (bus.dec_take),
        .o_cnt     (w_cnt),
        .o_rem     (w_rem),
        .o_slot    (w_slot)
    );

    assign bus.fetch_pc0  = r_pc;
    assign bus.fetch_pc1  = w_pc4;
    assign bus.fetch_pc2  = w_pc8;
    assign bus.fetch_en   = w_fetch_en;
    assign bus.dec_valid  = (w_cnt != 2'd0);
    assign bus.dec_mask   = {w_cnt == 2'd3, w_cnt >= 2'd2, w_cnt >= 2'd1};
    assign bus.dec_pc0    = w_slot[0].pc;
    assign bus.dec_pc1    = w_slot[1].pc;
    assign bus.dec_pc2    = w_slot[2].pc;
    assign bus.dec_instr0 = w_slot[0].instr;
    assign bus.dec_instr1 = w_slot[1].instr;
    assign bus.dec_instr2 = w_slot[2].instr;
endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: queue-based reference model, decoupled monitor.
module tb_fetch_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_seq_if bus();
    fetch_seq #(.RESET_PC(32'h0040_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Instruction memory: data is a scrambled copy of its address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction
    always_comb begin
        bus.instr0 = mem(bus.fetch_pc0);
        bus.instr1 = mem(bus.fetch_pc1);
        bus.instr2 = mem(bus.fetch_pc2);
    end

    typedef struct packed {
        logic [31:0] fpc0, fpc1, fpc2;
        logic        fen, dv;
        logic [2:0]  mask;
        logic [31:0] p0, p1, p2, i0, i1, i2;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, ex);
        end
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            cmp("fetch_pc0", bus.fetch_pc0, mon_e.fpc0);
            cmp("fetch_pc1", bus.fetch_pc1, mon_e.fpc1);
            cmp("fetch_pc2", bus.fetch_pc2, mon_e.fpc2);
            cmp("fetch_en", 32'(bus.fetch_en), 32'(mon_e.fen));
            cmp("dec_valid", 32'(bus.dec_valid), 32'(mon_e.dv));
            cmp("dec_mask", 32'(bus.dec_mask), 32'(mon_e.mask));
            cmp("dec_pc0", bus.dec_pc0, mon_e.p0);
            cmp("dec_pc1", bus.dec_pc1, mon_e.p1);
            cmp("dec_pc2", bus.dec_pc2, mon_e.p2);
            cmp("dec_instr0", bus.dec_instr0, mon_e.i0);
            cmp("dec_instr1", bus.dec_instr1, mon_e.i1);
            cmp("dec_instr2", bus.dec_instr2, mon_e.i2);
        end
    end

    function automatic logic [31:0] slot_pc(input int k);
        return (k < m_q.size()) ? m_q[k] : 32'd0;
    endfunction

    // One cycle: drive at negedge, predict outputs, advance the model at posedge.
    task automatic step(input logic rst, input logic [1:0] take, input logic rd, input logic [31:0] rpc);
        exp_t e;
        int   n, te, rem;
        @(negedge clk);
        rst_n              = ~rst;
        bus.dec_take       = take;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        if (rst) begin
            m_pc = 32'h0040_0000;
            m_q.delete();
        end
        n   = m_q.size();
        te  = (int'(take) > n) ? n : int'(take);
        rem = n - te;
        e.fpc0 = m_pc;
        e.fpc1 = m_pc + 32'd4;
        e.fpc2 = m_pc + 32'd8;
        e.fen  = (rem == 0) && !rd;
        e.dv   = (n != 0);
        e.mask = 3'((1 << n) - 1);
        e.p0   = slot_pc(0);
        e.p1   = slot_pc(1);
        e.p2   = slot_pc(2);
        e.i0   = (n > 0) ? mem(e.p0) : 32'd0;
        e.i1   = (n > 1) ? mem(e.p1) : 32'd0;
        e.i2   = (n > 2) ? mem(e.p2) : 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (rd) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else if (rem == 0) begin
                m_q.delete();
                for (int k = 0; k < 3; k++) m_q.push_back(m_pc + 32'(4 * k));
                m_pc = m_pc + 32'd12;
            end else begin
                repeat (te) void'(m_q.pop_front());
            end
        end
    endtask

    initial begin
        bus.dec_take       = 2'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        m_pc               = 32'h0040_0000;
        repeat (2) step(1'b1, 2'd0, 1'b0, 32'd0);
        repeat (6) step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b0, 2'd1, 1'b0, 32'd0);
        step(1'b0, 2'd2, 1'b0, 32'd0);
        repeat (3) step(1'b0, 2'd0, 1'b0, 32'd0);
        // Reset lands while the buffer is full.
        step(1'b1, 2'd0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 2'd0, 1'b0, 32'd0);
        step(1'b0, 2'd3, 1'b1, 32'h0040_1002);
        repeat (3) step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b0, 2'd0, 1'b1, 32'hFFFF_FFF8);
        repeat (3) step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b0, 2'd2, 1'b0, 32'd0);
        step(1'b0, 2'd3, 1'b0, 32'd0);
        repeat (2) step(1'b0, 2'd1, 1'b0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [31:0] rpc;
            r   = $urandom_range(0, 63);
            rpc = (r == 1) ? 32'hFFFF_FFF4 : 32'($urandom);
            step(r == 0, 2'($urandom_range(0, 3)), (r > 0) && (r < 6), rpc);
        end
        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
